// File: rtl/decoder_scan_if.sv
// decoder_scan_if: groups the decoder's control inputs and its decoded
// outputs. The controller side (master) drives En/Mode/A. The decoder
// side (slave) drives Y/Idx/Wrap.
interface decoder_scan_if #(
    parameter int N = 2
);
    logic                 En;
    logic                 Mode;
    logic [N-1:0]         A;
    logic [(1 << N)-1:0]  Y;
    logic [N-1:0]         Idx;
    logic                 Wrap;

    modport master (
        output En,
        output Mode,
        output A,
        input  Y,
        input  Idx,
        input  Wrap
    );

    modport slave (
        input  En,
        input  Mode,
        input  A,
        output Y,
        output Idx,
        output Wrap
    );
endinterface

// File: rtl/decoder_scan.sv
// decoder_scan: registered N-to-2^N one-hot (or one-cold) decoder.
// Direct mode decodes A with one cycle of latency. Scan mode walks the
// active line across all outputs. Each line dwells for DIV cycles, and
// Wrap pulses as the index rolls from the last line back to line 0.
// The operating state is a pure function of En/Mode on every cycle. It
// steers the next-value logic, and the result is registered on the next
// edge, so no extra cycle of mode latency is added.
module decoder_scan #(
    parameter int N          = 2,
    parameter int DIV        = 4,
    parameter int ACTIVE_LOW = 0
) (
    input  logic            clk,
    input  logic            rst,
    decoder_scan_if.slave   bus
);

    localparam int W  = 1 << N;
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [N-1:0]  IDX_LAST = '1;
    localparam logic [W-1:0]  Y_OFF    = {W{(ACTIVE_LOW != 0)}};

    typedef enum logic [1:0] {
        ST_OFF,
        ST_DIRECT,
        ST_SCAN
    } op_state_t;

    op_state_t       state;

    logic [N-1:0]    idx_q;
    logic [N-1:0]    idx_d;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_d;
    logic [W-1:0]    y_q;
    logic [W-1:0]    y_d;
    logic            wrap_q;
    logic            wrap_d;

    // One line is active for a valid index. Polarity is applied here, so
    // the rest of the logic only reasons about which index is selected.
    function automatic logic [W-1:0] decode(input logic [N-1:0] sel);
        logic [W-1:0] hot;
        hot      = '0;
        hot[sel] = 1'b1;
        return (ACTIVE_LOW != 0) ? ~hot : hot;
    endfunction

    // Classify the current cycle from En/Mode. En=0 overrides Mode.
    always_comb begin
        state = ST_OFF;
        if (bus.En) begin
            state = bus.Mode ? ST_SCAN : ST_DIRECT;
        end
    end

    // Next-value logic for index, dwell counter, decoded output and wrap.
    // Y is always derived from a single index, so it cannot go multi-hot,
    // even on a mode-switch cycle.
    always_comb begin
        idx_d  = idx_q;
        cnt_d  = '0;
        y_d    = Y_OFF;
        wrap_d = 1'b0;
        unique case (state)
            ST_OFF: begin
                idx_d = idx_q;
            end
            ST_DIRECT: begin
                idx_d = bus.A;
                y_d   = decode(bus.A);
            end
            ST_SCAN: begin
                if (cnt_q == CNT_LAST) begin
                    idx_d  = idx_q + N'(1);
                    cnt_d  = '0;
                    y_d    = decode(idx_q + N'(1));
                    wrap_d = (idx_q == IDX_LAST);
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    y_d   = decode(idx_q);
                end
            end
            default: begin
                y_d = Y_OFF;
            end
        endcase
    end

    // Register all state. Reset discards any scan in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q  <= '0;
            cnt_q  <= '0;
            y_q    <= Y_OFF;
            wrap_q <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            cnt_q  <= cnt_d;
            y_q    <= y_d;
            wrap_q <= wrap_d;
        end
    end

    assign bus.Y    = y_q;
    assign bus.Idx  = idx_q;
    assign bus.Wrap = wrap_q;

endmodule

// File: tb/tb_decoder_scan.sv
// tb_decoder_scan: drives two decoder instances with the same inputs.
// dut0 uses N=2, DIV=4, active-high outputs.
// dut1 uses N=2, DIV=1, active-low outputs.
// Each instance has a behavioural model. The bench also applies a
// constant vector table and hand-written corner sequences.
module tb_decoder_scan;

    typedef struct {
        int idx;
        int cnt;
        int y;
        bit wrap;
    } model_t;

    typedef struct {
        bit rst;
        bit en;
        bit mode;
        int a;
        int y;
        int idx;
        bit wrap;
    } vec_t;

    localparam int LINES = 4;

    logic clk = 1'b0;
    logic rst;

    int     checks = 0;
    int     errors = 0;
    model_t m0;
    model_t m1;
    vec_t   vecs[$];

    // Free-running clock with a 10 ns period.
    always #5 clk = ~clk;

    decoder_scan_if #(.N(2)) bus0 ();
    decoder_scan_if #(.N(2)) bus1 ();

    decoder_scan #(.N(2), .DIV(4), .ACTIVE_LOW(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    decoder_scan #(.N(2), .DIV(1), .ACTIVE_LOW(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    // Output pattern for a selected line at the given polarity.
    function automatic int lineValue(int sel, bit al);
        int hot;
        hot = 1 << sel;
        return al ? ((~hot) & ((1 << LINES) - 1)) : hot;
    endfunction

    // Output pattern with no line selected.
    function automatic int offValue(bit al);
        return al ? ((1 << LINES) - 1) : 0;
    endfunction

    // Behavioural model of one clock edge.
    function automatic model_t modelStep(model_t m, int div, bit al,
                                         bit r, bit e, bit md, int a);
        model_t n;
        n = m;
        n.wrap = 1'b0;
        if (r) begin
            n.idx = 0;
            n.cnt = 0;
            n.y   = offValue(al);
        end else if (!e) begin
            n.cnt = 0;
            n.y   = offValue(al);
        end else if (!md) begin
            n.idx = a % LINES;
            n.cnt = 0;
            n.y   = lineValue(n.idx, al);
        end else if (m.cnt == div - 1) begin
            n.wrap = (m.idx == LINES - 1);
            n.idx  = (m.idx + 1) % LINES;
            n.cnt  = 0;
            n.y    = lineValue(n.idx, al);
        end else begin
            n.cnt = m.cnt + 1;
            n.y   = lineValue(m.idx, al);
        end
        return n;
    endfunction

    task automatic checkValue(string name, int actual, int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t",
                     name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of inputs, advance both models over the edge, then
    // settle 1 ns past the edge before any sampling.
    task automatic applyStimulus(bit r, bit e, bit md, int a);
        rst       = r;
        bus0.En   = e;
        bus0.Mode = md;
        bus0.A    = 2'(a);
        bus1.En   = e;
        bus1.Mode = md;
        bus1.A    = 2'(a);
        @(posedge clk);
        m0 = modelStep(m0, 4, 1'b0, r, e, md, a);
        m1 = modelStep(m1, 1, 1'b1, r, e, md, a);
        #1;
    endtask

    // Compare both instances against their models and check line count.
    task automatic checkOutput();
        checkValue("dut0 Y", int'(bus0.Y), m0.y);
        checkValue("dut0 Idx", int'(bus0.Idx), m0.idx);
        checkValue("dut0 Wrap", int'(bus0.Wrap), int'(m0.wrap));
        checkValue("dut1 Y", int'(bus1.Y), m1.y);
        checkValue("dut1 Idx", int'(bus1.Idx), m1.idx);
        checkValue("dut1 Wrap", int'(bus1.Wrap), int'(m1.wrap));
        checkValue("dut0 hot count<=1", int'($countones(bus0.Y) <= 1), 1);
        checkValue("dut1 hot count<=1", int'($countones(~bus1.Y) <= 1), 1);
    endtask

    function automatic vec_t mk(bit r, bit e, bit md, int a,
                                int y, int idx, bit w);
        vec_t v;
        v.rst  = r;
        v.en   = e;
        v.mode = md;
        v.a    = a;
        v.y    = y;
        v.idx  = idx;
        v.wrap = w;
        return v;
    endfunction

    // Stop with a failure if the run exceeds its time budget.
    initial begin
        #200000;
        $display("[TB] FAIL timeout: got no finish, expected finish by 200000");
        $fatal(1, "[TB] timeout");
    end

    // Main test sequence.
    initial begin
        bit e;
        bit md;
        bit r;

        rst       = 1'b1;
        bus0.En   = 1'b0;
        bus0.Mode = 1'b0;
        bus0.A    = '0;
        bus1.En   = 1'b0;
        bus1.Mode = 1'b0;
        bus1.A    = '0;

        // Columns: rst, en, mode, A, then expected dut0 Y, Idx and Wrap.
        vecs.push_back(mk(1, 1, 0, 2, 4'b0000, 0, 0));
        vecs.push_back(mk(1, 1, 0, 2, 4'b0000, 0, 0));
        vecs.push_back(mk(0, 1, 0, 2, 4'b0100, 2, 0));
        vecs.push_back(mk(0, 1, 0, 0, 4'b0001, 0, 0));
        vecs.push_back(mk(0, 1, 0, 1, 4'b0010, 1, 0));
        vecs.push_back(mk(0, 1, 0, 2, 4'b0100, 2, 0));
        vecs.push_back(mk(0, 1, 0, 3, 4'b1000, 3, 0));
        vecs.push_back(mk(0, 1, 0, 2, 4'b0100, 2, 0));
        vecs.push_back(mk(0, 1, 1, 0, 4'b0100, 2, 0));
        vecs.push_back(mk(0, 1, 1, 1, 4'b0100, 2, 0));
        vecs.push_back(mk(0, 1, 1, 3, 4'b0100, 2, 0));
        vecs.push_back(mk(0, 1, 1, 0, 4'b1000, 3, 0));
        vecs.push_back(mk(0, 1, 1, 2, 4'b1000, 3, 0));
        vecs.push_back(mk(0, 1, 1, 1, 4'b1000, 3, 0));
        vecs.push_back(mk(0, 1, 1, 0, 4'b1000, 3, 0));
        vecs.push_back(mk(0, 1, 1, 3, 4'b0001, 0, 1));
        vecs.push_back(mk(0, 1, 1, 0, 4'b0001, 0, 0));
        vecs.push_back(mk(0, 1, 1, 2, 4'b0001, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 4'b0001, 0, 0));
        vecs.push_back(mk(0, 1, 1, 1, 4'b0010, 1, 0));
        vecs.push_back(mk(0, 1, 1, 0, 4'b0010, 1, 0));
        vecs.push_back(mk(0, 1, 1, 3, 4'b0010, 1, 0));
        vecs.push_back(mk(0, 1, 1, 0, 4'b0010, 1, 0));
        vecs.push_back(mk(0, 1, 1, 0, 4'b0100, 2, 0));

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].en, vecs[i].mode, vecs[i].a);
            checkOutput();
            checkValue($sformatf("vec%0d Y", i), int'(bus0.Y), vecs[i].y);
            checkValue($sformatf("vec%0d Idx", i), int'(bus0.Idx), vecs[i].idx);
            checkValue($sformatf("vec%0d Wrap", i), int'(bus0.Wrap), int'(vecs[i].wrap));
        end

        // Disable in mid-dwell: advance the counter to 2, then drop En.
        applyStimulus(0, 1, 1, 0);
        checkOutput();
        applyStimulus(0, 1, 1, 0);
        checkOutput();
        applyStimulus(0, 0, 1, 0);
        checkOutput();
        checkValue("off Y", int'(bus0.Y), 4'b0000);
        checkValue("off Idx held", int'(bus0.Idx), 2);

        // Re-enable: the held line restarts its dwell from zero.
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(0, 1, 1, 3);
            checkOutput();
            checkValue($sformatf("reen%0d Y", k), int'(bus0.Y),
                       (k < 4) ? 4'b0100 : 4'b1000);
            checkValue($sformatf("reen%0d Idx", k), int'(bus0.Idx),
                       (k < 4) ? 2 : 3);
        end

        // Switch from scan to direct with the counter at 1.
        applyStimulus(0, 1, 1, 0);
        checkOutput();
        applyStimulus(0, 1, 0, 1);
        checkOutput();
        checkValue("scan->direct Y", int'(bus0.Y), 4'b0010);
        checkValue("scan->direct Idx", int'(bus0.Idx), 1);
        checkValue("scan->direct Wrap", int'(bus0.Wrap), 0);

        // Assert reset on the edge where the scan would otherwise wrap.
        applyStimulus(0, 1, 0, 3);
        checkOutput();
        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, 1, 1, 0);
            checkOutput();
        end
        applyStimulus(1, 1, 1, 0);
        checkOutput();
        checkValue("rst mid-scan Y", int'(bus0.Y), 4'b0000);
        checkValue("rst mid-scan Idx", int'(bus0.Idx), 0);
        checkValue("rst mid-scan Wrap", int'(bus0.Wrap), 0);
        checkValue("dut1 rst Y", int'(bus1.Y), 4'b1111);

        // dut1 with DIV=1 and active-low outputs advances every cycle.
        for (int k = 1; k <= 8; k++) begin
            applyStimulus(0, 1, 1, 0);
            checkOutput();
            checkValue($sformatf("dut1 step%0d Y", k), int'(bus1.Y),
                       lineValue(k % 4, 1'b1));
            checkValue($sformatf("dut1 step%0d Wrap", k), int'(bus1.Wrap),
                       int'(k % 4 == 0));
        end

        // Random traffic with sticky mode and occasional reset.
        e  = 1'b1;
        md = 1'b1;
        for (int k = 0; k < 400; k++) begin
            r = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 9) == 0) e = ~e;
            if ($urandom_range(0, 7) == 0) md = ~md;
            applyStimulus(r, e, md, int'($urandom_range(0, 3)));
            checkOutput();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
